// File: rtl/fft_stage_unpack.sv
// Butterfly-order to natural-order frame unpacker.
// Scatters accepted sample pairs into a frame buffer, then streams it out linearly.
module fft_stage_unpack #(
    parameter int SAMPLES = 16,
    parameter int WIDTH   = 3,
    parameter int STAGE   = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_lo,
    input  logic [WIDTH-1:0]           in_hi,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(SAMPLES)-1:0] out_index,
    output logic                       out_last,
    output logic                       frame_err
);

    localparam int AW   = $clog2(SAMPLES);
    localparam int PW   = AW - 1;
    localparam int HALF = SAMPLES / 2;

    localparam logic [AW-1:0] J_MASK = AW'((1 << STAGE) - 1);
    localparam logic [AW-1:0] HI_OFF = AW'(1 << STAGE);
    localparam logic [PW-1:0] P_END  = PW'(HALF - 1);
    localparam logic [AW-1:0] R_END  = AW'(SAMPLES - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    p_q;
    logic [AW-1:0]    r_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             frame_err_q;
    logic [WIDTH-1:0] mem_q [SAMPLES];

    logic          in_acc;
    logic          out_acc;
    logic          p_last;
    logic          r_last;
    logic [AW-1:0] p_ext;
    logic [AW-1:0] lo_addr;
    logic [AW-1:0] hi_addr;

    assign in_acc  = in_valid && in_ready_q;
    assign out_acc = out_valid_q && out_ready;
    assign p_last  = (p_q == P_END);
    assign r_last  = (r_q == R_END);

    // Group index lands above the pair-distance bit, offset stays below it.
    assign p_ext   = {1'b0, p_q};
    assign lo_addr = ((p_ext >> STAGE) << (STAGE + 1)) | (p_ext & J_MASK);
    assign hi_addr = lo_addr + HI_OFF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            p_q         <= '0;
            r_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (in_acc) begin
                        if (p_last) begin
                            p_q         <= '0;
                            r_q         <= '0;
                            state_q     <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            if (!in_last) frame_err_q <= 1'b1;
                        end else begin
                            p_q <= p_q + 1'b1;
                            if (in_last) frame_err_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_acc) begin
                        if (r_last) begin
                            r_q         <= '0;
                            state_q     <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            r_q <= r_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    // Frame buffer carries no reset; contents are only read during DRAIN.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            mem_q[lo_addr] <= in_lo;
            mem_q[hi_addr] <= in_hi;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_index = r_q;
    assign out_data  = out_valid_q ? mem_q[r_q] : '0;
    assign out_last  = out_valid_q && r_last;
    assign frame_err = frame_err_q;

endmodule

// File: doc/fft_stage_unpack.md
Name: fft_stage_unpack

Overview:
Streaming inverse of the butterfly pair ordering used ahead of an FFT stage. It accepts sample pairs serially in butterfly order for stage STAGE, where each pair is (index n, index n + 2^STAGE). It scatters the pairs into an internal frame buffer. Once the frame is full, it streams the samples back out in natural order 0..SAMPLES-1. It sits on the output side of a butterfly stage and restores linear sample order for display or for the next stage's reordering.

Parameters:
- SAMPLES, 16: samples per frame. Power of two, at least 4.
- WIDTH, 3: bits per sample.
- STAGE, 3: butterfly stage; pair distance is 2^STAGE. Legal range 0 .. $clog2(SAMPLES)-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an input pair is presented.
- in_ready  output  1  block can accept a pair.
- in_lo  input  WIDTH  sample for the lower index of the pair.
- in_hi  input  WIDTH  sample for the upper index (lower + 2^STAGE).
- in_last  input  1  marks the final pair of a frame.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  sample in natural order.
- out_index  output  $clog2(SAMPLES)  natural index of out_data.
- out_last  output  1  asserted with index SAMPLES-1.
- frame_err  output  1  sticky in_last mismatch flag.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=FILL, pair counter p=0, read index r=0.
  - in_ready=1 once reset is released; out_valid=0, out_last=0, out_index=0, out_data=0, frame_err=0.
  - Buffer contents are don't-care.
  - Reset mid-frame discards the partial frame with no output.
- States:
  - FILL: in_ready=1, out_valid=0.
  - DRAIN: in_ready=0, out_valid=1.
  - No overlap between states; single buffer.
- Pair addressing for pair p in 0 .. SAMPLES/2-1:
  - g = p >> STAGE; j = p & (2^STAGE - 1).
  - lo = (g << (STAGE+1)) + j; hi = lo + 2^STAGE.
  - All arithmetic is $clog2(SAMPLES) bits wide with no overflow by construction.
- FILL handshake:
  - A pair is accepted on a cycle where in_valid && in_ready. Then mem[lo] <= in_lo, mem[hi] <= in_hi, p <= p+1.
  - When p == SAMPLES/2-1 is accepted: p <= 0, r <= 0, go to DRAIN. out_valid rises the next cycle (1-cycle latency from the final accept).
- in_last checking:
  - in_last is sampled only on accept.
  - Accepted with in_last=1 while p != SAMPLES/2-1 → frame_err <= 1. The frame is NOT truncated; the count still governs.
  - Final pair accepted with in_last=0 → frame_err <= 1.
  - frame_err clears only on reset.
- DRAIN outputs:
  - out_data = mem[r], out_index = r, out_last = (r == SAMPLES-1).
  - Data must come from registered/buffered storage, with no combinational path from in_* to out_*.
- DRAIN handshake:
  - On out_valid && out_ready: r <= r+1.
  - out_ready low holds out_data, out_index and out_last stable.
  - On accept with r == SAMPLES-1: go to FILL; in_ready=1 the next cycle.
  - No wrap of r within DRAIN.
- Ignored inputs: in_valid during DRAIN and out_ready during FILL are ignored.
- Throughput: one pair per cycle in FILL and one sample per cycle in DRAIN, giving 1.5·SAMPLES cycles per frame at full rate.

Test Plan:
- Defaults (SAMPLES=16, STAGE=3): send pairs p=0..7 as (lo=p, hi=p+8) with in_lo=p%8, in_hi=(p+8)%8 and in_last on p=7. Required: out_valid rises 1 cycle after the 8th accept; out_data sequence is 0,1,...,7,0,...,7; out_index runs 0..15; out_last only at 15; frame_err=0.
- STAGE=0 override: pairs (0,1),(2,3),...,(14,15) with values equal to index mod 8. Required: natural-order output identical to the first test.
- STAGE=1 override: pair order 0/2, 1/3, 4/6, 5/7, .... Drive in_lo=3, in_hi=5 on the first pair. Required: out_index 0 gives 3 and out_index 2 gives 5.
- Backpressure: hold out_ready=0 for 5 cycles at r=4. Required: out_data and out_index stay at 4 with no advance; toggling in_valid meanwhile has no effect (in_ready=0).
- in_last asserted on p=3 (defaults). Required: frame_err=1 from the next cycle; all 8 pairs are still consumed; 16 outputs produced; a following clean frame leaves frame_err=1.
- Assert reset_n=0 after 4 pairs, then release. Required: all outputs return immediately to their reset values; a full new frame then drains correctly with no stale samples emitted first.
